// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: requester request/response handshakes plus the
// single-port data memory bus served by data_mem_arbiter.
interface data_mem_arbiter_if #(
   parameter int unsigned ADDRESS_WIDTH = 8,
   parameter int unsigned DATA_WIDTH    = 8
);
   logic                     req0_valid_i;
   logic                     req0_ready_o;
   logic                     req0_wr_i;
   logic [ADDRESS_WIDTH-1:0] req0_addr_i;
   logic [DATA_WIDTH-1:0]    req0_wdata_i;
   logic                     rsp0_valid_o;
   logic [DATA_WIDTH-1:0]    rsp0_rdata_o;

   logic                     req1_valid_i;
   logic                     req1_ready_o;
   logic                     req1_wr_i;
   logic [ADDRESS_WIDTH-1:0] req1_addr_i;
   logic [DATA_WIDTH-1:0]    req1_wdata_i;
   logic                     rsp1_valid_o;
   logic [DATA_WIDTH-1:0]    rsp1_rdata_o;

   logic                     mem_wr_en_o;
   logic [ADDRESS_WIDTH-1:0] mem_addr_o;
   logic [DATA_WIDTH-1:0]    mem_wdata_o;
   logic [DATA_WIDTH-1:0]    mem_rdata_i;

   // Arbiter side
   modport slave (
      input  req0_valid_i, req0_wr_i, req0_addr_i, req0_wdata_i,
      output req0_ready_o, rsp0_valid_o, rsp0_rdata_o,
      input  req1_valid_i, req1_wr_i, req1_addr_i, req1_wdata_i,
      output req1_ready_o, rsp1_valid_o, rsp1_rdata_o,
      output mem_wr_en_o, mem_addr_o, mem_wdata_o,
      input  mem_rdata_i
   );

   // Requesters plus memory side
   modport master (
      output req0_valid_i, req0_wr_i, req0_addr_i, req0_wdata_i,
      input  req0_ready_o, rsp0_valid_o, rsp0_rdata_o,
      output req1_valid_i, req1_wr_i, req1_addr_i, req1_wdata_i,
      input  req1_ready_o, rsp1_valid_o, rsp1_rdata_o,
      input  mem_wr_en_o, mem_addr_o, mem_wdata_o,
      output mem_rdata_i
   );
endinterface

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin two-requester front end for a single-port
// synchronous data memory. Optional owner locking via DATA_MEM_ARB_LOCK_EN.
module data_mem_arbiter #(
   parameter int unsigned ADDRESS_WIDTH   = 8,
   parameter int unsigned DATA_WIDTH      = 8,
   parameter int unsigned MAX_LOCK_CYCLES = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
`ifdef DATA_MEM_ARB_LOCK_EN
   input  logic [1:0]        req_lock_i,
`endif
   data_mem_arbiter_if.slave bus
);

   typedef enum logic {
      GRANT_REQ0 = 1'b0,
      GRANT_REQ1 = 1'b1
   } grant_e;

   if (MAX_LOCK_CYCLES < 1) begin : g_bad_lock_cycles
      $error("MAX_LOCK_CYCLES must be at least 1");
   end

   grant_e r_last_grant;
   logic   r_rd_pending;
   grant_e r_rd_owner;

   logic   w_gnt_valid;
   grant_e w_gnt_idx;
   logic   w_gnt_wr;

`ifdef DATA_MEM_ARB_LOCK_EN
   localparam int unsigned LOCK_CW = $clog2(MAX_LOCK_CYCLES + 1);

   logic               r_lock_active;
   grant_e             r_lock_owner;
   logic [LOCK_CW-1:0] r_lock_cnt;
   logic               w_lock_hold;
   logic               w_gnt_lock;

   assign w_lock_hold = r_lock_active &&
                        ((r_lock_owner == GRANT_REQ1) ? (bus.req1_valid_i && req_lock_i[1])
                                                      : (bus.req0_valid_i && req_lock_i[0]));
   assign w_gnt_lock  = (w_gnt_idx == GRANT_REQ1) ? req_lock_i[1] : req_lock_i[0];
`endif

   // Reset gates the grant so every output is 0 while rst_ni is low.
   always_comb begin
      w_gnt_valid = rst_ni && (bus.req0_valid_i || bus.req1_valid_i);
      w_gnt_idx   = GRANT_REQ0;
      if (bus.req0_valid_i && bus.req1_valid_i) begin
         w_gnt_idx = (r_last_grant == GRANT_REQ0) ? GRANT_REQ1 : GRANT_REQ0;
      end else if (bus.req1_valid_i) begin
         w_gnt_idx = GRANT_REQ1;
      end
`ifdef DATA_MEM_ARB_LOCK_EN
      if (w_lock_hold) begin
         w_gnt_idx = r_lock_owner;
      end
`endif
      w_gnt_wr = (w_gnt_idx == GRANT_REQ1) ? bus.req1_wr_i : bus.req0_wr_i;
   end

   assign bus.req0_ready_o = w_gnt_valid && (w_gnt_idx == GRANT_REQ0);
   assign bus.req1_ready_o = w_gnt_valid && (w_gnt_idx == GRANT_REQ1);

   assign bus.mem_wr_en_o  = w_gnt_valid && w_gnt_wr;
   assign bus.mem_addr_o   = !w_gnt_valid ? '0 :
                             (w_gnt_idx == GRANT_REQ1) ? bus.req1_addr_i : bus.req0_addr_i;
   assign bus.mem_wdata_o  = !w_gnt_valid ? '0 :
                             (w_gnt_idx == GRANT_REQ1) ? bus.req1_wdata_i : bus.req0_wdata_i;

   assign bus.rsp0_valid_o = r_rd_pending && (r_rd_owner == GRANT_REQ0);
   assign bus.rsp1_valid_o = r_rd_pending && (r_rd_owner == GRANT_REQ1);
   assign bus.rsp0_rdata_o = bus.rsp0_valid_o ? bus.mem_rdata_i : '0;
   assign bus.rsp1_rdata_o = bus.rsp1_valid_o ? bus.mem_rdata_i : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_last_grant <= GRANT_REQ1;
         r_rd_pending <= 1'b0;
         r_rd_owner   <= GRANT_REQ0;
      end else begin
         if (w_gnt_valid) begin
            r_last_grant <= w_gnt_idx;
         end
         r_rd_pending <= w_gnt_valid && !w_gnt_wr;
         if (w_gnt_valid && !w_gnt_wr) begin
            r_rd_owner <= w_gnt_idx;
         end
      end
   end

`ifdef DATA_MEM_ARB_LOCK_EN
   // Hitting the limit drops ownership with last_grant on the owner, so the
   // round-robin rule hands the next contention to the other requester.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_lock_active <= 1'b0;
         r_lock_owner  <= GRANT_REQ0;
         r_lock_cnt    <= '0;
      end else if (w_gnt_valid && w_lock_hold) begin
         if (r_lock_cnt == LOCK_CW'(MAX_LOCK_CYCLES - 1)) begin
            r_lock_active <= 1'b0;
            r_lock_cnt    <= '0;
         end else begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
         end
      end else if (w_gnt_valid && w_gnt_lock) begin
         r_lock_active <= (MAX_LOCK_CYCLES > 1);
         r_lock_owner  <= w_gnt_idx;
         r_lock_cnt    <= LOCK_CW'((MAX_LOCK_CYCLES > 1) ? 1 : 0);
      end else begin
         r_lock_active <= 1'b0;
         r_lock_cnt    <= '0;
      end
   end
`endif

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Two-requester arbiter in front of the single-port synchronous data memory (one access per cycle, write-or-read, registered read data).
- Requester 0 is the core load/store path; requester 1 is a secondary master (debug/DMA loader).
- Grants one request per cycle using round-robin with valid/ready handshakes, drives the memory port, and routes the read data back to the originating requester one cycle later.

Parameters:
- ADDRESS_WIDTH, 8, memory address width; must match the data memory.
- DATA_WIDTH, 8, memory data width; must match the data memory.
- MAX_LOCK_CYCLES, 16, maximum consecutive grants a locked requester may hold (used only with the optional feature); must be >= 1.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req0_valid_i  in  1  requester 0 has a request.
- req0_ready_o  out  1  requester 0 request accepted this cycle.
- req0_wr_i  in  1  1 = write, 0 = read.
- req0_addr_i  in  ADDRESS_WIDTH  address.
- req0_wdata_i  in  DATA_WIDTH  write data.
- rsp0_valid_o  out  1  read data valid for requester 0.
- rsp0_rdata_o  out  DATA_WIDTH  read data.
- req1_* and rsp1_*  same set of ports and meanings, for requester 1.
- mem_wr_en_o  out  1  to memory write enable.
- mem_addr_o  out  ADDRESS_WIDTH  to memory address.
- mem_wdata_o  out  DATA_WIDTH  to memory write data.
- mem_rdata_i  in  DATA_WIDTH  from memory registered read data.

Behaviour:
- Handshake: a transfer occurs when reqN_valid_i && reqN_ready_o. ready is combinational from valid and arbiter state. At most one ready is high per cycle. A requester holds valid, wr, addr and wdata stable until ready.
- Arbitration state: 1-bit last_grant register, reset to 1 so requester 0 wins the first contention.
- Only one valid: that requester is granted.
- Both valid: the requester != last_grant is granted.
- last_grant updates to the granted index on every transfer and is unchanged on idle cycles.
- Memory drive, combinational from the grant: mem_addr_o/mem_wdata_o = granted requester's fields; mem_wr_en_o = granted && wr. With no grant: mem_wr_en_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
- Read response:
  - Read granted in cycle N → registered tag {rd_pending, rd_owner} set at the end of N.
  - In cycle N+1: rspX_valid_o = 1 for X = rd_owner, and rspX_rdata_o = mem_rdata_i.
  - Non-owner rsp_valid = 0; its rdata is driven 0.
- Writes produce no response and complete at the grant edge.
- No response backpressure; requesters must accept rsp_valid.
- Back-to-back reads from either requester run at full throughput, 1 read/cycle.
- A read the cycle after a write to the same address returns the new data (memory writes at edge N, reads at edge N+1).
- A write in the cycle after a read does not disturb the pending response: the memory holds data_o during writes.
- Reset, asynchronous and at any time including a pending read:
  - last_grant = 1, rd_pending = 0, rd_owner = 0, lock counter = 0.
  - All outputs = 0 while rst_ni is low.
  - An in-flight read response is dropped and never issued after reset release.

Optional Feature:
- Macro DATA_MEM_ARB_LOCK_EN.
- Defined:
  - Adds input req_lock_i[1:0].
  - If the granted requester has its lock bit high at grant, it becomes the owner. While it keeps valid && lock high, it is granted exclusively, regardless of round-robin.
  - A lock counter increments per owner grant. When it reaches MAX_LOCK_CYCLES, ownership releases for one arbitration: if the other requester is valid it wins the next cycle, then normal rules resume.
  - Ownership ends when lock drops, when the owner deasserts valid, or on reset.
- Undefined: the port is absent, with no lock state; pure round-robin.

Test Plan:
- Req0 writes 0xA5 to 0x10, then reads 0x10 → mem_wr_en_o = 1 in cycle 0; rsp0_valid_o = 1 with rsp0_rdata_o = 0xA5 exactly one cycle after the read grant; rsp1_valid_o stays 0.
- Both valid every cycle for 6 cycles, reads to 0x01 (req0) and 0x02 (req1) → grants alternate 0,1,0,1,0,1; each response goes to the correct owner with the data preloaded at its address.
- Req1 read of 0x20 (holding 0x3C), followed next cycle by a req0 write of 0x77 to 0x21 → rsp1 gets 0x3C in the write cycle; memory[0x21] = 0x77.
- Idle cycles with both valid low → mem_wr_en_o = 0 and mem_addr_o = 0; last_grant unchanged, so the next contention still alternates correctly.
- Reset asserted asynchronously mid-cycle right after a read grant → all outputs drop immediately; no rsp_valid after release; first contention grants req0.
- With DATA_MEM_ARB_LOCK_EN and MAX_LOCK_CYCLES = 4: req0 locked and valid continuously, req1 valid → req0 granted 4 cycles, then req1 granted 1 cycle, then req0 again.
